serial_compare_scheduler: RTL and testbench
===========================================

Name: serial_compare_scheduler

Overview:
- Shares one bit-serial magnitude comparator (1-bit/cycle, MSB-first, sticky E/L flops, synchronous active-high init, G = not(E or L)) between two requesters.
- Round-robin arbitration; captures the winner's operand pair and pulses the comparator init.
- Shifts WIDTH bit pairs MSB-first, samples E/L/G and returns a tagged result over a valid/ready handshake.

Parameters:
- WIDTH, 8, operand width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock; all flops rising-edge.
- reset  input  1  asynchronous, active-low reset (reset = 0 clears all state immediately).
- req_valid  input  2  bit i = requester i has an operand pair pending.
- req_ready  output  2  bit i = requester i's pair is accepted this cycle; at most one bit high.
- x0, y0  input  WIDTH each  requester 0 operands.
- x1, y1  input  WIDTH each  requester 1 operands.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  result consumer accepts.
- rsp_id  output  1  requester that owns the result.
- rsp_eq, rsp_lt, rsp_gt  output  1 each  x==y, x<y, x>y (unsigned), one-hot.
- cmp_x, cmp_y  output  1 each  serial bit to comparator.
- cmp_init  output  1  comparator init (E<=1, L<=0 at next edge).
- cmp_e, cmp_l, cmp_g  input  1 each  comparator state outputs.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset values:
  - state = IDLE, req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_eq/lt/gt = 0.
  - cmp_x = cmp_y = 0, cmp_init = 0, busy = 0.
  - last_grant = 1, so requester 0 wins first.
  - Shift registers and counter are cleared.
- FSM states: IDLE, INIT, SHIFT, SAMPLE, RESP.
- IDLE:
  - Grant when exactly one req_valid bit is high.
  - If both are high, grant the index != last_grant.
  - req_ready[grant] is high combinationally.
  - On that edge: load the operand pair into the shift registers, set owner = grant and last_grant = grant, then go to INIT.
  - No req_valid bit high: stay in IDLE.
- INIT (1 cycle): cmp_init = 1, cmp_x = cmp_y = 0. Counter loaded to WIDTH-1. Next state is SHIFT.
- SHIFT (WIDTH cycles):
  - cmp_x and cmp_y are the MSBs of the shift registers; both registers shift left by 1 per edge.
  - The counter decrements each edge; at 0, go to SAMPLE.
- SAMPLE (1 cycle):
  - cmp_x = cmp_y = 0 (equal zeros hold comparator state).
  - On the edge, register rsp_eq = cmp_e, rsp_lt = cmp_l, rsp_gt = cmp_g, rsp_id = owner; go to RESP.
- RESP:
  - rsp_valid = 1; all rsp_* fields stable until handshake.
  - rsp_valid & rsp_ready: go to IDLE and clear rsp_valid next cycle. No new request is accepted in the same cycle.
  - Back-pressure: stays in RESP indefinitely with cmp_x = cmp_y = 0.
- Latency:
  - Accept edge T; cmp_init high in cycle T+1; serial bits in cycles T+2 .. T+WIDTH+1; rsp_valid high from T+WIDTH+3.
  - Minimum request-to-request period is WIDTH+4 cycles.
- Outside SHIFT, cmp_x = cmp_y = 0. cmp_init is high only in INIT.
- req_ready is 0 in all states except IDLE.
- Operand changes on x*/y* after acceptance have no effect.
- A requester that drops req_valid before grant is simply not served; no state is kept.
- Asynchronous reset mid-operation aborts the comparison with no response. The next operation restarts with an INIT cycle.
- Result encodings other than one-hot (comparator fault) are passed through unmodified.

Test Plan:
- Single request: WIDTH=8, req_valid=01, x0=0x5A, y0=0x5A, rsp_ready=1 -> req_ready=01 one cycle; cmp_init one cycle; 8 bits 0,1,0,1,1,0,1,0 on both lines; rsp_valid at T+11 with id=0, eq=1, lt=0, gt=0.
- Less/greater: x1=0x80, y1=0x7F -> gt=1, id=1; then x0=0x03, y0=0x04 -> lt=1, id=0.
- Simultaneous requests: req_valid=11 held through three rounds after reset -> grants 0, 1, 0 in order; each rsp_id matches its grant.
- Back-pressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and fields stable, req_ready=00, cmp_x/cmp_y=0; release -> IDLE the next cycle.
- Reset mid-SHIFT: reset low at the 4th serial bit -> all outputs to reset values immediately. A new request x0=0xFF, y0=0x00 -> gt=1, unaffected by the aborted operation.
- WIDTH=1 build: x0=1, y0=0 -> single SHIFT cycle, gt=1, rsp_valid at T+4.

Source files
------------

// File: rtl/serial_compare_scheduler_if.sv
// Request/response bundle between two requesters, the result consumer and the
// serial comparator scheduler.
interface serial_compare_scheduler_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] y1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic             rsp_eq;
  logic             rsp_lt;
  logic             rsp_gt;

  modport master (
    output req_valid, x0, y0, x1, y1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_gt
  );

  modport slave (
    input  req_valid, x0, y0, x1, y1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_gt
  );
endinterface

// File: rtl/serial_compare_scheduler.sv
// Round-robin sharing of one external bit-serial magnitude comparator between
// two requesters; operands go out MSB-first and a tagged result comes back.
module serial_compare_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  serial_compare_scheduler_if.slave bus,
  output logic cmp_x,
  output logic cmp_y,
  output logic cmp_init,
  input  logic cmp_e,
  input  logic cmp_l,
  input  logic cmp_g,
  output logic busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, INIT, SHIFT, SAMPLE, RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_sh_q, x_sh_d;
  logic [WIDTH-1:0] y_sh_q, y_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_eq_q, rsp_eq_d;
  logic             rsp_lt_q, rsp_lt_d;
  logic             rsp_gt_q, rsp_gt_d;
  logic             cmp_init_q, cmp_init_d;
  logic             busy_q, busy_d;
  logic             grant_valid;
  logic             grant;

  // With both requesters pending, serve the one that was not served last.
  always_comb begin
    grant = 1'b0;
    case (bus.req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = ~last_grant_q;
    endcase
  end

  assign grant_valid   = (state_q == IDLE) && (bus.req_valid != 2'b00);
  assign bus.req_ready = grant_valid ? (grant ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d      = state_q;
    x_sh_d       = x_sh_q;
    y_sh_d       = y_sh_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_eq_d     = rsp_eq_q;
    rsp_lt_d     = rsp_lt_q;
    rsp_gt_d     = rsp_gt_q;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          x_sh_d       = grant ? bus.x1 : bus.x0;
          y_sh_d       = grant ? bus.y1 : bus.y0;
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = INIT;
        end
      end
      INIT: begin
        cnt_d   = CNT_LAST;
        state_d = SHIFT;
      end
      SHIFT: begin
        x_sh_d = x_sh_q << 1;
        y_sh_d = y_sh_q << 1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = SAMPLE;
        end
      end
      // Comparator flags are passed through as-is, even if not one-hot.
      SAMPLE: begin
        rsp_eq_d    = cmp_e;
        rsp_lt_d    = cmp_l;
        rsp_gt_d    = cmp_g;
        rsp_id_d    = owner_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmp_init_d = (state_d == INIT);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      x_sh_q       <= '0;
      y_sh_q       <= '0;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_eq_q     <= 1'b0;
      rsp_lt_q     <= 1'b0;
      rsp_gt_q     <= 1'b0;
      cmp_init_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_sh_q       <= x_sh_d;
      y_sh_q       <= y_sh_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_eq_q     <= rsp_eq_d;
      rsp_lt_q     <= rsp_lt_d;
      rsp_gt_q     <= rsp_gt_d;
      cmp_init_q   <= cmp_init_d;
      busy_q       <= busy_d;
    end
  end

  // Zero pairs outside SHIFT leave the sticky comparator state untouched.
  assign cmp_x    = (state_q == SHIFT) & x_sh_q[WIDTH-1];
  assign cmp_y    = (state_q == SHIFT) & y_sh_q[WIDTH-1];
  assign cmp_init = cmp_init_q;
  assign busy     = busy_q;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_eq    = rsp_eq_q;
  assign bus.rsp_lt    = rsp_lt_q;
  assign bus.rsp_gt    = rsp_gt_q;
endmodule

// File: tb/tb_serial_compare_scheduler.sv
// Bench for serial_compare_scheduler: a behavioural serial comparator plus a
// scoreboard of expected tagged results, for WIDTH=8 and WIDTH=1 builds.
module tb_serial_compare_scheduler;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic id;
    logic eq;
    logic lt;
    logic gt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic model_clear;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  serial_compare_scheduler_if #(.WIDTH(WIDTH)) bus ();
  serial_compare_scheduler_if #(.WIDTH(1))     bus1 ();

  logic cmp_x, cmp_y, cmp_init, cmp_e, cmp_l, cmp_g, busy;
  logic cmp_x1, cmp_y1, cmp_init1, cmp_e1, cmp_l1, cmp_g1, busy1;

  serial_compare_scheduler #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cmp_x(cmp_x), .cmp_y(cmp_y), .cmp_init(cmp_init),
    .cmp_e(cmp_e), .cmp_l(cmp_l), .cmp_g(cmp_g), .busy(busy)
  );

  serial_compare_scheduler #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .cmp_x(cmp_x1), .cmp_y(cmp_y1), .cmp_init(cmp_init1),
    .cmp_e(cmp_e1), .cmp_l(cmp_l1), .cmp_g(cmp_g1), .busy(busy1)
  );

  // Comparator models are deliberately not cleared by the DUT reset.
  logic ce, cl, ce1, cl1;
  always @(posedge clk) begin
    if (model_clear) begin
      ce <= 1'b1; cl <= 1'b0;
    end else if (cmp_init) begin
      ce <= 1'b1; cl <= 1'b0;
    end else if (ce && (cmp_x != cmp_y)) begin
      ce <= 1'b0; cl <= cmp_y;
    end
  end
  always @(posedge clk) begin
    if (model_clear) begin
      ce1 <= 1'b1; cl1 <= 1'b0;
    end else if (cmp_init1) begin
      ce1 <= 1'b1; cl1 <= 1'b0;
    end else if (ce1 && (cmp_x1 != cmp_y1)) begin
      ce1 <= 1'b0; cl1 <= cmp_y1;
    end
  end
  assign cmp_e  = ce;
  assign cmp_l  = cl;
  assign cmp_g  = ~(ce | cl);
  assign cmp_e1 = ce1;
  assign cmp_l1 = cl1;
  assign cmp_g1 = ~(ce1 | cl1);

  // Returns the number of cycles waited for the grant (-1 on timeout); after
  // acceptance the operands are scrambled to show they were captured.
  task automatic send(input int idx, input logic [WIDTH-1:0] x,
                      input logic [WIDTH-1:0] y, output int n);
    exp_t e;
    @(negedge clk);
    if (idx == 0) begin bus.x0 = x; bus.y0 = y; end
    else          begin bus.x1 = x; bus.y1 = y; end
    bus.req_valid = (idx == 0) ? 2'b01 : 2'b10;
    #1;
    n = 0;
    while (bus.req_ready[idx] !== 1'b1 && n < 60) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 60) n = -1;
    else begin
      e.id = (idx != 0); e.eq = (x == y); e.lt = (x < y); e.gt = (x > y);
      sb.push_back(e);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    if (idx == 0) begin bus.x0 = ~x; bus.y0 = ~y; end
    else          begin bus.x1 = ~x; bus.y1 = ~y; end
    #1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (bus.rsp_valid !== 1'b1) begin
      if (n >= 60) begin n = -1; return; end
      @(negedge clk); #1; n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; model_clear = 1'b1;
    bus.req_valid = 2'b00; bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
    bus.rsp_ready = 1'b1;
    bus1.req_valid = 2'b00; bus1.x0 = '0; bus1.y0 = '0; bus1.x1 = '0; bus1.y1 = '0;
    bus1.rsp_ready = 1'b1;
    #2;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_lt, bus.rsp_gt,
         cmp_x, cmp_y, cmp_init, busy} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b required all zero",
               {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_lt,
                bus.rsp_gt, cmp_x, cmp_y, cmp_init, busy});
    end
    repeat (2) @(negedge clk);
    model_clear = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, bus.rsp_valid, bus1.rsp_valid, busy1} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_release: got %b required 0000",
               {busy, bus.rsp_valid, bus1.rsp_valid, busy1});
    end
  endtask

  task automatic test_single;
    int n;
    exp_t e;
    logic [WIDTH-1:0] pat;
    pat = 8'h5A;
    send(0, 8'h5A, 8'h5A, n);
    checks++;
    if (n !== 0) begin
      errors++; $display("[TB] FAIL single_grant_wait: got %0d required 0", n);
    end
    checks++;
    if ({bus.req_ready, cmp_init, cmp_x, cmp_y, busy} !== 6'b00_1001) begin
      errors++;
      $display("[TB] FAIL single_init_cycle: got %b required 001001",
               {bus.req_ready, cmp_init, cmp_x, cmp_y, busy});
    end
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({cmp_x, cmp_y, cmp_init} !== {pat[WIDTH-1-i], pat[WIDTH-1-i], 1'b0}) begin
        errors++;
        $display("[TB] FAIL single_bit%0d: got %b required %b", i,
                 {cmp_x, cmp_y, cmp_init}, {pat[WIDTH-1-i], pat[WIDTH-1-i], 1'b0});
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.rsp_valid, cmp_x, cmp_y} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL single_sample_cycle: got %b required 000",
               {bus.rsp_valid, cmp_x, cmp_y});
    end
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL single_rsp_latency: got valid=%b required 1 at T+11",
               bus.rsp_valid);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({bus.rsp_id, bus.rsp_eq, bus.rsp_lt, bus.rsp_gt} !== e) begin
        errors++;
        $display("[TB] FAIL single_result: got %b required %b",
                 {bus.rsp_id, bus.rsp_eq, bus.rsp_lt, bus.rsp_gt}, e);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.rsp_valid, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL single_return_idle: got %b required 00", {bus.rsp_valid, busy});
    end
  endtask

  task automatic test_less_greater;
    int n;
    exp_t e;
    logic [WIDTH-1:0] xs [2];
    logic [WIDTH-1:0] ys [2];
    int ids [2];
    xs[0] = 8'h80; ys[0] = 8'h7F; ids[0] = 1;
    xs[1] = 8'h03; ys[1] = 8'h04; ids[1] = 0;
    for (int k = 0; k < 2; k++) begin
      send(ids[k], xs[k], ys[k], n);
      wait_rsp(n);
      checks++;
      if (n !== 10) begin
        errors++; $display("[TB] FAIL lg%0d_latency: got %0d required 10", k, n);
      end
      if (n >= 0 && sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({bus.rsp_id, bus.rsp_eq, bus.rsp_lt, bus.rsp_gt} !== e) begin
          errors++;
          $display("[TB] FAIL lg%0d_result: got %b required %b", k,
                   {bus.rsp_id, bus.rsp_eq, bus.rsp_lt, bus.rsp_gt}, e);
        end
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_round_robin;
    int n;
    exp_t e;
    logic exp_grant;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    sb.delete();
    bus.x0 = 8'h10; bus.y0 = 8'h20; bus.x1 = 8'h30; bus.y1 = 8'h30;
    @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    exp_grant = 1'b0;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (bus.req_ready === 2'b00 && n < 60) begin @(negedge clk); #1; n++; end
      checks++;
      if (bus.req_ready !== (exp_grant ? 2'b10 : 2'b01)) begin
        errors++;
        $display("[TB] FAIL rr_grant%0d: got %b required %b", r, bus.req_ready,
                 exp_grant ? 2'b10 : 2'b01);
      end
      e.id = exp_grant;
      e.eq = exp_grant;
      e.lt = ~exp_grant;
      e.gt = 1'b0;
      sb.push_back(e);
      @(negedge clk); #1;
      wait_rsp(n);
      checks++;
      if (n < 0 || sb.size() == 0) begin
        errors++; $display("[TB] FAIL rr_rsp%0d_timeout: got %0d required >=0", r, n);
      end else begin
        e = sb.pop_front();
        if ({bus.rsp_id, bus.rsp_eq, bus.rsp_lt, bus.rsp_gt} !== e) begin
          errors++;
          $display("[TB] FAIL rr_result%0d: got %b required %b", r,
                   {bus.rsp_id, bus.rsp_eq, bus.rsp_lt, bus.rsp_gt}, e);
        end
      end
      exp_grant = ~exp_grant;
      @(negedge clk); #1;
    end
    bus.req_valid = 2'b00;
    #1;
  endtask

  task automatic test_back_pressure;
    int n;
    exp_t e;
    bus.rsp_ready = 1'b0;
    send(0, 8'hC3, 8'hC4, n);
    wait_rsp(n);
    checks++;
    if (n < 0 || sb.size() == 0) begin
      errors++; $display("[TB] FAIL bp_rsp_timeout: got %0d required >=0", n);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    bus.req_valid = 2'b11;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_lt, bus.rsp_gt,
           bus.req_ready, cmp_x, cmp_y} !== {1'b1, e, 2'b00, 2'b00}) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got %b required %b", i,
                 {bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_lt, bus.rsp_gt,
                  bus.req_ready, cmp_x, cmp_y}, {1'b1, e, 2'b00, 2'b00});
      end
      @(negedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL bp_handshake_cycle: got %b required 100",
               {bus.rsp_valid, bus.req_ready});
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    checks++;
    if ({bus.rsp_valid, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL bp_release_idle: got %b required 00", {bus.rsp_valid, busy});
    end
  endtask

  task automatic test_reset_mid_shift;
    int n;
    exp_t e;
    send(0, 8'h3C, 8'hA5, n);
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if ({cmp_x, cmp_y} !== 2'b10) begin
      errors++; $display("[TB] FAIL rm_fourth_bit: got %b required 10", {cmp_x, cmp_y});
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_lt, bus.rsp_gt,
         cmp_x, cmp_y, cmp_init, busy} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL rm_async_clear: got %b required all zero",
               {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.rsp_lt,
                bus.rsp_gt, cmp_x, cmp_y, cmp_init, busy});
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    send(0, 8'hFF, 8'h00, n);
    wait_rsp(n);
    checks++;
    if (n !== 10 || sb.size() == 0) begin
      errors++; $display("[TB] FAIL rm_restart_latency: got %0d required 10", n);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({bus.rsp_id, bus.rsp_eq, bus.rsp_lt, bus.rsp_gt} !== e) begin
        errors++;
        $display("[TB] FAIL rm_restart_result: got %b required %b",
                 {bus.rsp_id, bus.rsp_eq, bus.rsp_lt, bus.rsp_gt}, e);
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_width1;
    exp_t e;
    @(negedge clk);
    bus1.x0 = 1'b1; bus1.y0 = 1'b0; bus1.rsp_ready = 1'b1; bus1.req_valid = 2'b01;
    #1;
    checks++;
    if (bus1.req_ready !== 2'b01) begin
      errors++; $display("[TB] FAIL w1_grant: got %b required 01", bus1.req_ready);
    end
    e.id = 1'b0; e.eq = 1'b0; e.lt = 1'b0; e.gt = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus1.req_valid = 2'b00; bus1.x0 = 1'b0; bus1.y0 = 1'b1;
    #1;
    checks++;
    if ({cmp_init1, cmp_x1, cmp_y1} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL w1_init: got %b required 100", {cmp_init1, cmp_x1, cmp_y1});
    end
    @(negedge clk); #1;
    checks++;
    if ({cmp_init1, cmp_x1, cmp_y1} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL w1_shift: got %b required 010", {cmp_init1, cmp_x1, cmp_y1});
    end
    @(negedge clk); #1;
    checks++;
    if ({bus1.rsp_valid, cmp_x1, cmp_y1} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL w1_sample: got %b required 000", {bus1.rsp_valid, cmp_x1, cmp_y1});
    end
    @(negedge clk); #1;
    checks++;
    if (bus1.rsp_valid !== 1'b1 || sb.size() == 0) begin
      errors++; $display("[TB] FAIL w1_latency: got valid=%b required 1 at T+4", bus1.rsp_valid);
    end else begin
      e = sb.pop_front();
      checks++;
      if ({bus1.rsp_id, bus1.rsp_eq, bus1.rsp_lt, bus1.rsp_gt} !== e) begin
        errors++;
        $display("[TB] FAIL w1_result: got %b required %b",
                 {bus1.rsp_id, bus1.rsp_eq, bus1.rsp_lt, bus1.rsp_gt}, e);
      end
    end
    @(negedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_less_greater();
    test_round_robin();
    test_back_pressure();
    test_reset_mid_shift();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d errors so far", errors);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
